// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide unit producing one result bit per cycle.
// Optional feature: define MULDIV_FAST_MUL_EN to make all multiplies single-cycle combinational.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic             Zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   hi_q, lo_q, opnd_q, c_q;
  logic               neg_q, neg_rem_q, fin_q, direct_q, busy_q, done_q;

  logic               a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, direct_val_s;
  logic               div_zero_s, div_ovf_s, direct_s, accept_s;
  logic [WIDTH:0]     mul_sum_s, rem_sh_s;
  logic [WIDTH+1:0]   diff_s;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s, result_s;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod_s;
`endif

  assign accept_s = start && ((state_q == IDLE) || (state_q == DONE));

  // Operand decode: magnitudes, sign flags and results that need no iteration
  always_comb begin
    a_signed_s   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed_s   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg_s      = a_signed_s && A[WIDTH-1];
    b_neg_s      = b_signed_s && B[WIDTH-1];
    a_mag_s      = a_neg_s ? -A : A;
    b_mag_s      = b_neg_s ? -B : B;
    div_zero_s   = op[2] && (B == '0);
    div_ovf_s    = ((op == OP_DIV) || (op == OP_REM)) && (A == MIN_NEG) && (B == '1);
    direct_s     = div_zero_s || div_ovf_s;
    direct_val_s = '0;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod_s  = {{WIDTH{a_neg_s}}, A} * {{WIDTH{b_neg_s}}, B};
    if (!op[2]) begin
      direct_s     = 1'b1;
      direct_val_s = (op == OP_MUL) ? fast_prod_s[WIDTH-1:0] : fast_prod_s[2*WIDTH-1:WIDTH];
    end else
`endif
    if (div_zero_s) begin
      direct_val_s = op[1] ? A : '1;
    end else if (div_ovf_s) begin
      direct_val_s = op[1] ? '0 : A;
    end else begin
      direct_val_s = '0;
    end
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_sh_s  = {hi_q, lo_q[WIDTH-1]};
    diff_s    = {1'b0, rem_sh_s} - {2'b00, opnd_q};
    if (op_q[2]) begin
      if (diff_s[WIDTH+1:WIDTH] == 2'b00) begin
        hi_d = diff_s[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = rem_sh_s[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum_s[WIDTH:1];
      lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction and result selection once the iterations are finished
  always_comb begin
    prod_s     = {hi_q, lo_q};
    prod_fix_s = neg_q ? -prod_s : prod_s;
    quo_fix_s  = neg_q ? -lo_q : lo_q;
    rem_fix_s  = neg_rem_q ? -hi_q : hi_q;
    if (direct_q) begin
      result_s = lo_q;
    end else begin
      case (op_q)
        OP_MUL:                       result_s = prod_fix_s[WIDTH-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: result_s = prod_fix_s[2*WIDTH-1:WIDTH];
        OP_DIV, OP_DIVU:              result_s = quo_fix_s;
        OP_REM, OP_REMU:              result_s = rem_fix_s;
        default:                      result_s = '0;
      endcase
    end
  end

  // Control FSM and datapath registers; a direct result waits one cycle in CALC with fin set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 3'b000;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      fin_q     <= 1'b0;
      direct_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      c_q       <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else if (accept_s) begin
      state_q   <= CALC;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      op_q      <= op;
      cnt_q     <= CNT_W'(WIDTH - 1);
      neg_q     <= a_neg_s ^ b_neg_s;
      neg_rem_q <= a_neg_s;
      hi_q      <= '0;
      opnd_q    <= op[2] ? b_mag_s : a_mag_s;
      lo_q      <= direct_s ? direct_val_s : (op[2] ? a_mag_s : b_mag_s);
      fin_q     <= direct_s;
      direct_q  <= direct_s;
    end else begin
      case (state_q)
        CALC: begin
          if (fin_q) begin
            c_q     <= result_s;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CNT_W'(1);
            fin_q <= (cnt_q == '0);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign C    = c_q;
  assign Zero = (c_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M corner cases plus randomized traffic
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] A = '0, B = '0;
  logic         busy, done, Zero;
  logic [W-1:0] C;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B), .flush(flush),
    .busy(busy), .done(done), .C(C), .Zero(Zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           due;
    logic [2:0]   op;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32M semantics in plain 64-bit arithmetic
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    longint pa, pb;
    logic [63:0] p;
    sa = int'(a);
    sb = int'(b);
    case (o)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin pa = sa; pb = sb; p = pa * pb; return p[63:32]; end
      3'd2: begin pa = sa; pb = longint'({32'd0, b}); p = pa * pb; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == '0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == '0) return '1;
        return a / b;
      end
      3'd6: begin
        if (b == '0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == '0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int lat(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    if (o[2]) begin
      if (b == '0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == '1)) return 1;
      return W + 1;
    end else begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return W + 1;
`endif
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // Hold start with the new operands until the unit can accept, then log the expectation
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output logic dacc);
    int n;
    exp_t e;
    op = o; A = a; B = b; start = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: busy=%0b, expected 0", busy);
    end
    dacc  = done;
    e.res = model(o, a, b);
    e.due = cyc + 1 + lat(o, a, b);
    e.op  = o;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
    end
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: done=1 with nothing outstanding, C=%h, expected no done", C);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("C_op%0d", e.op), C, e.res);
        chk("Zero", {31'd0, Zero}, {31'd0, (e.res == '0)});
        chk("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  logic         dacc;
  logic [W-1:0] prior;

  initial begin
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_C", C, 32'd0);
    chk("reset_Zero", {31'd0, Zero}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, dacc);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, dacc);
    issue(3'd3, 32'h8000_0000, 32'h8000_0000, dacc);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dacc);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, dacc);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, dacc);
    issue(3'd5, 32'd100, 32'd7, dacc);
    issue(3'd7, 32'd100, 32'd7, dacc);
    issue(3'd5, 32'd5, 32'd0, dacc);
    issue(3'd6, 32'd5, 32'd0, dacc);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, dacc);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, dacc);
    drain();

    // A start pulse while busy must not disturb the in-flight divide
    issue(3'd5, 32'd1000, 32'd7, dacc);
    repeat (3) @(negedge clk);
    op = 3'd4; A = 32'h1234_5678; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    prior = model(3'd5, 32'd1000, 32'd7);

    // Flush mid-divide: drops the op, no done, C keeps the previous result
    issue(3'd5, 32'hFFFF_0000, 32'd3, dacc);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    void'(sbq.pop_back());
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_C", C, prior);
    repeat (40) @(negedge clk);

    // Flush beats a start presented in IDLE
    flush = 1'b1; start = 1'b1; op = 3'd5; A = 32'd9; B = 32'd2;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Back-to-back: second start held high is taken in the DONE cycle
    issue(3'd5, 32'd1000, 32'd3, dacc);
    issue(3'd7, 32'd1000, 32'd3, dacc);
    chk("b2b_accept_in_done", {31'd0, dacc}, 32'd1);
    drain();

    // Reset in the middle of a multiply
    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, dacc);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_C", C, 32'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(3'd3, 32'hFFFF_FFFF, 32'd2, dacc);
    drain();

    // Randomized traffic with occasional idle gaps
    for (int i = 0; i < 150; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      if ($urandom_range(0, 19) == 0) begin
        ra = 32'h8000_0000;
        rb = '1;
      end
      issue(ro, ra, rb, dacc);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
